// File: rtl/qoa_pkg.sv
// qoa_pkg: shared constants, types and helpers for the QOA sample decoder.
//   - SfTab / dq_mag : scalefactor table and dequantised magnitude ROM (16 x 4)
//   - Op*            : SPI command opcodes
//   - SampleW/AccW   : sample and MAC accumulator widths
//   - spi_state_e    : command FSM states; lms_state_e: LMS sequencer states
// Optional build macro QOA_STATE_READBACK_EN enables the READ (0x30) command.
package qoa_pkg;

  localparam int unsigned SampleW       = 16;
  localparam int unsigned AccW          = 34;
  localparam int unsigned PredShift     = 13;
  // Slowest clk/SCLK ratio the front end is designed to keep up with.
  localparam int unsigned ClkPerSclkMin = 16;

  localparam logic [7:0] OpLoad   = 8'h10;
  localparam logic [7:0] OpDecode = 8'h20;
  localparam logic [7:0] OpRead   = 8'h30;

  localparam logic [15:0] SfTab [16] = '{
    16'd1,    16'd7,    16'd21,   16'd45,   16'd84,   16'd138,  16'd211,  16'd304,
    16'd421,  16'd562,  16'd731,  16'd928,  16'd1157, 16'd1419, 16'd1715, 16'd2048
  };

  typedef enum logic [2:0] {
    StIdle, StCmd, StLoad, StDecArg, StCompute, StResp, StIgnore, StRead
  } spi_state_e;

  typedef enum logic [1:0] {LmsIdle, LmsMac, LmsFinish} lms_state_e;

  // Round-half-up of SfTab[sf] * {0.75, 2.5, 4.5, 7}[msel]; constant ROM once synthesised.
  function automatic logic [15:0] dq_mag(input logic [3:0] sf, input logic [1:0] msel);
    logic [15:0] s;
    s = SfTab[sf];
    case (msel)
      2'd0:    dq_mag = (s * 16'd3 + 16'd2) >> 2;
      2'd1:    dq_mag = (s * 16'd5 + 16'd1) >> 1;
      2'd2:    dq_mag = (s * 16'd9 + 16'd1) >> 1;
      default: dq_mag = s * 16'd7;
    endcase
  endfunction

endpackage

// File: rtl/qoa_lms.sv
// qoa_lms: QOA LMS predictor core.
//   Holds history h[0..3] and weights w[0..3]; on start_i dequantises (sf_i, r_i),
//   runs a 4-cycle MAC on one shared 16x16 multiplier, clamps to int16, updates
//   weights, shifts history and pulses done_o with sample_o valid.
//   load_en_i/load_idx_i/load_data_i write one state word (idx 0-3 = h, 4-7 = w).
//   With QOA_STATE_READBACK_EN, rd_idx_i/rd_data_o read a state word back.
module qoa_lms
  import qoa_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  sf_i,
  input  logic [2:0]  r_i,
  input  logic        load_en_i,
  input  logic [2:0]  load_idx_i,
  input  logic [15:0] load_data_i,
`ifdef QOA_STATE_READBACK_EN
  input  logic [2:0]  rd_idx_i,
  output logic [15:0] rd_data_o,
`endif
  output logic        done_o,
  output logic [15:0] sample_o
);

  localparam logic signed [AccW-1:0] ClampHi = AccW'(32767);
  localparam logic signed [AccW-1:0] ClampLo = AccW'(-32768);

  lms_state_e                state_q;
  logic [1:0]                mac_idx_q;
  logic signed [AccW-1:0]    acc_q;
  logic signed [SampleW-1:0] dq_q;
  logic signed [SampleW-1:0] hist_q [4];
  logic signed [SampleW-1:0] wgt_q  [4];
  logic [SampleW-1:0]        sample_q;
  logic                      done_q;

  logic [15:0]               mag;
  logic signed [31:0]        prod;
  logic signed [AccW-1:0]    prod_ext;
  logic signed [AccW-1:0]    pred;
  logic signed [AccW-1:0]    pred_sum;
  logic signed [SampleW-1:0] delta;
  logic signed [SampleW-1:0] sample_clamped;

  always_comb begin
    mag      = dq_mag(sf_i, r_i[2:1]);
    prod     = 32'(hist_q[mac_idx_q]) * 32'(wgt_q[mac_idx_q]);
    prod_ext = AccW'(prod);
    pred     = acc_q >>> PredShift;
    pred_sum = pred + AccW'(dq_q);
    delta    = dq_q >>> 4;
    if (pred_sum > ClampHi) begin
      sample_clamped = 16'sh7fff;
    end else if (pred_sum < ClampLo) begin
      sample_clamped = 16'sh8000;
    end else begin
      sample_clamped = pred_sum[SampleW-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= LmsIdle;
      mac_idx_q <= '0;
      acc_q     <= '0;
      dq_q      <= '0;
      sample_q  <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
        wgt_q[i]  <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (load_en_i) begin
        if (load_idx_i[2]) wgt_q[load_idx_i[1:0]]  <= load_data_i;
        else               hist_q[load_idx_i[1:0]] <= load_data_i;
      end
      case (state_q)
        LmsIdle: begin
          if (start_i) begin
            // Odd residual code selects the negative magnitude.
            dq_q      <= r_i[0] ? -mag : mag;
            acc_q     <= '0;
            mac_idx_q <= '0;
            state_q   <= LmsMac;
          end
        end
        LmsMac: begin
          acc_q     <= acc_q + prod_ext;
          mac_idx_q <= mac_idx_q + 2'd1;
          if (mac_idx_q == 2'd3) state_q <= LmsFinish;
        end
        LmsFinish: begin
          // Weight update uses the history before the shift.
          for (int i = 0; i < 4; i++) begin
            wgt_q[i] <= hist_q[i][SampleW-1] ? wgt_q[i] - delta : wgt_q[i] + delta;
          end
          for (int i = 0; i < 3; i++) begin
            hist_q[i] <= hist_q[i+1];
          end
          hist_q[3] <= sample_clamped;
          sample_q  <= sample_clamped;
          done_q    <= 1'b1;
          state_q   <= LmsIdle;
        end
        default: state_q <= LmsIdle;
      endcase
    end
  end

`ifdef QOA_STATE_READBACK_EN
  assign rd_data_o = rd_idx_i[2] ? wgt_q[rd_idx_i[1:0]] : hist_q[rd_idx_i[1:0]];
`endif
  assign done_o   = done_q;
  assign sample_o = sample_q;

endmodule

// File: rtl/qoa_decode.sv
// qoa_decode: Tiny Tapeout top for an SPI-attached QOA sample decoder.
//   clk, rst      : system clock, synchronous active-high reset
//   ena, ui_in    : unused
//   uo_out        : last decoded sample[15:8]
//   uio_in        : [0]=CS_N, [1]=MOSI, [3]=SCLK (SPI mode 0, MSB first)
//   uio_out       : [2]=MISO, other bits 0
//   uio_oe        : constant 8'b0000_0100
// Commands: 0x10 LOAD (16 bytes h0..h3,w0..w3 big-endian), 0x20 DECODE (one arg byte,
// then 16 bits of sample). Build macro QOA_STATE_READBACK_EN adds 0x30 READ.
module qoa_decode
  import qoa_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [1:0]  cs_sync_q, mosi_sync_q, sclk_sync_q;
  logic        sclk_prev_q;
  logic        cs_n, mosi, sclk, sclk_rise, sclk_fall;

  spi_state_e  state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  rx_sr_q;
  logic [3:0]  lb_cnt_q;
  logic [7:0]  load_hi_q;
  logic [15:0] tx_sr_q;
  logic [3:0]  tx_cnt_q;
  logic        tx_armed_q;

  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        lms_start, load_en, lms_done;
  logic [15:0] lms_sample;
  logic [15:0] tx_next;

`ifdef QOA_STATE_READBACK_EN
  logic [2:0]  word_idx_q;
  logic [3:0]  word_nxt;
  logic [2:0]  rd_idx;
  logic [15:0] rd_data;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{ena, ui_in, uio_in[7:4], uio_in[2]};

  assign cs_n      = cs_sync_q[1];
  assign mosi      = mosi_sync_q[1];
  assign sclk      = sclk_sync_q[1];
  assign sclk_rise = sclk & ~sclk_prev_q;
  assign sclk_fall = ~sclk & sclk_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], uio_in[0]};
      mosi_sync_q <= {mosi_sync_q[0], uio_in[1]};
      sclk_sync_q <= {sclk_sync_q[0], uio_in[3]};
      sclk_prev_q <= sclk;
    end
  end

  assign rx_byte   = {rx_sr_q[6:0], mosi};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  assign lms_start = !cs_n && byte_done && (state_q == StDecArg);
  // Odd LOAD byte completes a word together with the held high byte.
  assign load_en   = !cs_n && byte_done && (state_q == StLoad) && lb_cnt_q[0];

`ifdef QOA_STATE_READBACK_EN
  assign word_nxt = {1'b0, word_idx_q} + 4'd1;
  assign rd_idx   = (state_q == StCmd) ? 3'd0 : word_nxt[2:0];
`endif

  // Word shifted out after the current one completes; zeros once nothing is left.
  always_comb begin
    tx_next = '0;
`ifdef QOA_STATE_READBACK_EN
    if (state_q == StRead && !word_nxt[3]) tx_next = rd_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || cs_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      lb_cnt_q   <= '0;
      tx_sr_q    <= '0;
      tx_cnt_q   <= '0;
      tx_armed_q <= 1'b0;
      if (rst) begin
        rx_sr_q   <= '0;
        load_hi_q <= '0;
      end
`ifdef QOA_STATE_READBACK_EN
      word_idx_q <= '0;
`endif
    end else begin
      if (sclk_rise) begin
        rx_sr_q   <= rx_byte;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      case (state_q)
        StIdle: state_q <= StCmd;
        StCmd: begin
          if (byte_done) begin
            if (rx_byte == OpLoad) begin
              lb_cnt_q <= '0;
              state_q  <= StLoad;
            end else if (rx_byte == OpDecode) begin
              state_q <= StDecArg;
`ifdef QOA_STATE_READBACK_EN
            end else if (rx_byte == OpRead) begin
              tx_sr_q    <= rd_data;
              tx_cnt_q   <= '0;
              tx_armed_q <= 1'b0;
              word_idx_q <= '0;
              state_q    <= StRead;
`endif
            end else begin
              state_q <= StIgnore;
            end
          end
        end
        StLoad: begin
          if (byte_done) begin
            if (!lb_cnt_q[0]) load_hi_q <= rx_byte;
            lb_cnt_q <= lb_cnt_q + 4'd1;
            if (lb_cnt_q == 4'd15) state_q <= StIgnore;
          end
        end
        StDecArg: if (byte_done) state_q <= StCompute;
        StCompute: begin
          if (lms_done) begin
            tx_sr_q    <= lms_sample;
            tx_cnt_q   <= '0;
            tx_armed_q <= 1'b0;
            state_q    <= StResp;
          end
        end
        StResp, StRead: begin
          // The fall that ends the previous byte must not shift: wait for a rise first.
          if (sclk_rise) begin
            tx_cnt_q   <= tx_cnt_q + 4'd1;
            tx_armed_q <= 1'b1;
          end else if (sclk_fall && tx_armed_q) begin
            if (tx_cnt_q == 4'd0) begin
              tx_sr_q <= tx_next;
`ifdef QOA_STATE_READBACK_EN
              if (!word_nxt[3]) word_idx_q <= word_nxt[2:0];
`endif
            end else begin
              tx_sr_q <= {tx_sr_q[14:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  qoa_lms u_lms (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (lms_start),
    .sf_i        (rx_byte[3:0]),
    .r_i         (rx_byte[6:4]),
    .load_en_i   (load_en),
    .load_idx_i  (lb_cnt_q[3:1]),
    .load_data_i ({load_hi_q, rx_byte}),
`ifdef QOA_STATE_READBACK_EN
    .rd_idx_i    (rd_idx),
    .rd_data_o   (rd_data),
`endif
    .done_o      (lms_done),
    .sample_o    (lms_sample)
  );

  assign uo_out  = lms_sample[15:8];
  assign uio_out = {5'b00000, tx_sr_q[15], 2'b00};
  assign uio_oe  = 8'b0000_0100;

endmodule

// File: tb/tb_qoa_decode.sv
module tb_qoa_decode;

  localparam int Half = 10;  // clk cycles per SCLK half period

  logic       clk = 1'b0;
  logic       rst, ena;
  logic       cs_n, mosi, sclk;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic       miso;

  int checks = 0;
  int passes = 0;

  int sf_tab [16] = '{1, 7, 21, 45, 84, 138, 211, 304, 421, 562, 731, 928, 1157, 1419,
                      1715, 2048};
  int mh [4];
  int mw [4];

  always #5 clk = ~clk;

  assign uio_in = {4'b0000, sclk, 1'b0, mosi, cs_n};
  assign miso   = uio_out[2];

  qoa_decode dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // ---------------- reference model ----------------
  function automatic int wrap16(input int v);
    shortint s;
    s = shortint'(v);
    return int'(s);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      mh[i] = 0;
      mw[i] = 0;
    end
  endfunction

  function automatic void model_load(input logic [127:0] words, input int nbytes);
    for (int j = 0; j < nbytes / 2; j++) begin
      int v;
      v = int'($signed(words[127-16*j -: 16]));
      if (j < 4) mh[j] = v;
      else       mw[j-4] = v;
    end
  endfunction

  function automatic int model_decode(input logic [7:0] arg);
    int m4 [4] = '{3, 10, 18, 28};  // multiplier x4
    int sf, r, mag, dq, delta, smp;
    longint acc, pred;
    sf  = int'(arg[3:0]);
    r   = int'(arg[6:4]);
    mag = (sf_tab[sf] * m4[r / 2] + 2) / 4;
    dq  = (r % 2 == 1) ? -mag : mag;
    acc = 0;
    for (int i = 0; i < 4; i++) acc += longint'(mh[i]) * longint'(mw[i]);
    pred = acc >>> 13;
    if (pred + dq > 32767)       smp = 32767;
    else if (pred + dq < -32768) smp = -32768;
    else                         smp = int'(pred + dq);
    delta = dq >>> 4;
    for (int i = 0; i < 4; i++) mw[i] = wrap16(mw[i] + ((mh[i] < 0) ? -delta : delta));
    mh[0] = mh[1];
    mh[1] = mh[2];
    mh[2] = mh[3];
    mh[3] = smp;
    return smp;
  endfunction

  // ---------------- SPI host ----------------
  task automatic do_reset();
    rst  = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
  endtask

  task automatic spi_begin();
    cs_n = 1'b0;
    repeat (Half) @(negedge clk);
  endtask

  task automatic spi_end();
    repeat (Half) @(negedge clk);
    cs_n = 1'b1;
    repeat (Half) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (Half) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b1;
      repeat (Half) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic decode_txn(input logic [7:0] arg, output logic [15:0] got,
                            output logic [7:0] tail);
    logic [7:0] d, b0, b1;
    spi_begin();
    spi_byte(8'h20, d);
    spi_byte(arg, d);
    spi_byte(8'h00, b0);
    spi_byte(8'h00, b1);
    spi_byte(8'h00, tail);
    spi_end();
    got = {b0, b1};
  endtask

  task automatic load_txn(input logic [127:0] words, input int nbytes);
    logic [7:0] d;
    spi_begin();
    spi_byte(8'h10, d);
    for (int k = 0; k < nbytes; k++) spi_byte(words[127-8*k -: 8], d);
    spi_end();
    model_load(words, nbytes);
  endtask

  function automatic logic [127:0] rand_state();
    logic [127:0] w;
    for (int j = 0; j < 8; j++) begin
      if (j < 4) w[127-16*j -: 16] = 16'($urandom);
      else       w[127-16*j -: 16] = 16'(int'($urandom_range(0, 8191)) - 4096);
    end
    return w;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (uo_out !== 8'h00) $display("FAIL reset_uo_out: got %h want 00", uo_out);
    else passes++;
    checks++;
    if (uio_out !== 8'h00) $display("FAIL reset_uio_out: got %h want 00", uio_out);
    else passes++;
    checks++;
    if (uio_oe !== 8'h04) $display("FAIL reset_uio_oe: got %h want 04", uio_oe);
    else passes++;
  endtask

  task automatic test_decode_basic();
    logic [15:0] got;
    logic [7:0]  tail;
    int          exp;
    do_reset();
    exp = model_decode(8'h60);
    decode_txn(8'h60, got, tail);
    checks++;
    if (got !== 16'h0007) $display("FAIL dec_0x60: got %h want 0007", got);
    else passes++;
    checks++;
    if (tail !== 8'h00) $display("FAIL resp_tail_zero: got %h want 00", tail);
    else passes++;
    exp = model_decode(8'h00);
    decode_txn(8'h00, got, tail);
    checks++;
    if (got !== 16'(exp)) $display("FAIL dec_after_0x60: got %h want %h", got, 16'(exp));
    else passes++;

    do_reset();
    exp = model_decode(8'h6F);
    decode_txn(8'h6F, got, tail);
    checks++;
    if (got !== 16'h3800) $display("FAIL dec_0x6F: got %h want 3800", got);
    else passes++;
    checks++;
    if (uo_out !== 8'h38) $display("FAIL uo_out_0x6F: got %h want 38", uo_out);
    else passes++;
    exp = model_decode(8'h00);
    decode_txn(8'h00, got, tail);
    checks++;
    if (got !== 16'h0621) $display("FAIL dec_pred_1569: got %h want 0621", got);
    else passes++;
  endtask

  task automatic test_clamp();
    logic [15:0] got;
    logic [7:0]  tail;
    int          exp;
    do_reset();
    load_txn({{4{16'h7FFF}}, {4{16'h2000}}}, 16);
    exp = model_decode(8'h6F);
    decode_txn(8'h6F, got, tail);
    checks++;
    if (got !== 16'h7FFF) $display("FAIL clamp_hi: got %h want 7fff", got);
    else passes++;
    checks++;
    if (uo_out !== 8'h7F) $display("FAIL clamp_uo_out: got %h want 7f", uo_out);
    else passes++;
    exp = model_decode(8'h00);
    decode_txn(8'h00, got, tail);
    checks++;
    if (got !== 16'(exp)) $display("FAIL after_clamp: got %h want %h", got, 16'(exp));
    else passes++;
  endtask

  task automatic test_negative();
    logic [15:0] got;
    logic [7:0]  tail;
    int          exp;
    do_reset();
    exp = model_decode(8'h7F);
    decode_txn(8'h7F, got, tail);
    checks++;
    if (got !== 16'hC800) $display("FAIL dec_0x7F: got %h want c800", got);
    else passes++;
    checks++;
    if (uo_out !== 8'hC8) $display("FAIL uo_out_neg: got %h want c8", uo_out);
    else passes++;
    // Exercises the h<0 weight-update branch and negative prediction terms.
    for (int k = 0; k < 2; k++) begin
      exp = model_decode(8'h6F);
      decode_txn(8'h6F, got, tail);
      checks++;
      if (got !== 16'(exp)) $display("FAIL neg_follow%0d: got %h want %h", k, got, 16'(exp));
      else passes++;
    end
  endtask

  task automatic test_load_abort();
    logic [15:0] got;
    logic [7:0]  tail;
    logic [7:0]  arg;
    int          exp;
    do_reset();
    load_txn(rand_state(), 16);
    load_txn(rand_state(), 5);
    for (int k = 0; k < 2; k++) begin
      arg = 8'($urandom) & 8'h7F;
      exp = model_decode(arg);
      decode_txn(arg, got, tail);
      checks++;
      if (got !== 16'(exp))
        $display("FAIL load_abort%0d arg %h: got %h want %h", k, arg, got, 16'(exp));
      else passes++;
    end
  endtask

  task automatic test_unknown_opcode();
    logic [7:0]  d, r0, r1;
    logic [15:0] got;
    logic [7:0]  tail;
    int          exp;
    spi_begin();
    spi_byte(8'h55, d);
    spi_byte(8'h20, r0);
    spi_byte(8'h6F, r1);
    spi_end();
    checks++;
    if ({r0, r1} !== 16'h0000) $display("FAIL unknown_op_miso: got %h want 0000", {r0, r1});
    else passes++;
    exp = model_decode(8'h31);
    decode_txn(8'h31, got, tail);
    checks++;
    if (got !== 16'(exp)) $display("FAIL after_unknown: got %h want %h", got, 16'(exp));
    else passes++;
  endtask

  task automatic test_random();
    logic [15:0] got;
    logic [7:0]  tail;
    logic [7:0]  arg;
    int          exp;
    do_reset();
    for (int it = 0; it < 6; it++) begin
      load_txn(rand_state(), 16);
      for (int k = 0; k < 3; k++) begin
        arg = 8'($urandom) & 8'h7F;
        exp = model_decode(arg);
        decode_txn(arg, got, tail);
        checks++;
        if (got !== 16'(exp))
          $display("FAIL rand_dec it%0d.%0d arg %h: got %h want %h", it, k, arg, got, 16'(exp));
        else passes++;
        checks++;
        if (uo_out !== 8'(exp >> 8))
          $display("FAIL rand_uo_out it%0d.%0d: got %h want %h", it, k, uo_out, 8'(exp >> 8));
        else passes++;
      end
    end
  endtask

  task automatic test_readback();
    logic [127:0] pat;
    logic [127:0] want;
    logic [7:0]   d, b;
    int           bad;
    do_reset();
    pat = rand_state();
    load_txn(pat, 16);
`ifdef QOA_STATE_READBACK_EN
    want = pat;
`else
    want = '0;
`endif
    bad = 0;
    spi_begin();
    spi_byte(8'h30, d);
    for (int k = 0; k < 16; k++) begin
      spi_byte(8'h00, b);
      checks++;
      if (b !== want[127-8*k -: 8]) begin
        $display("FAIL readback_byte%0d: got %h want %h", k, b, want[127-8*k -: 8]);
        bad++;
      end else passes++;
    end
    spi_end();
  endtask

  task automatic test_reset_mid_compute();
    logic [7:0]  d;
    logic [7:0]  a;
    logic [15:0] got;
    logic [7:0]  tail;
    int          exp;
    do_reset();
    a = 8'h6F;
    spi_begin();
    spi_byte(8'h20, d);
    for (int i = 7; i >= 0; i--) begin
      mosi = a[i];
      repeat (Half) @(negedge clk);
      sclk = 1'b1;
      if (i > 0) begin
        repeat (Half) @(negedge clk);
        sclk = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    rst  = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    model_reset();
    checks++;
    if (uo_out !== 8'h00) $display("FAIL midreset_uo_out: got %h want 00", uo_out);
    else passes++;
    checks++;
    if (miso !== 1'b0) $display("FAIL midreset_miso: got %b want 0", miso);
    else passes++;
    exp = model_decode(8'h60);
    decode_txn(8'h60, got, tail);
    checks++;
    if (got !== 16'h0007) $display("FAIL midreset_dec: got %h want 0007", got);
    else passes++;
    exp = model_decode(8'h00);
    decode_txn(8'h00, got, tail);
    checks++;
    if (got !== 16'(exp)) $display("FAIL midreset_dec2: got %h want %h", got, 16'(exp));
    else passes++;
  endtask

  initial begin
    ena   = 1'b1;
    ui_in = 8'h00;
    rst   = 1'b1;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    test_reset();
    test_decode_basic();
    test_clamp();
    test_negative();
    test_load_abort();
    test_unknown_opcode();
    test_random();
    test_readback();
    test_reset_mid_compute();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
